// File: rtl/so3s_online.sv
// Radix-2 online (MSDF) sum of three squares, S = X^2 + Y^2 + Z^2, online delay 0.
// Digits are {plus, minus}; one output digit in [-7, 7] per input digit.
module so3s_online #(
  parameter int WIDTH           = 15,
  parameter int TRUNCATED_WIDTH = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic [1:0] z,
  output logic [3:0] s
);

  localparam int F  = TRUNCATED_WIDTH;
  localparam int PW = F + 2;
  localparam int WW = F + 5;
  localparam int JW = $clog2(WIDTH + 1);
  localparam logic signed [WW-1:0] HALF = WW'(1) <<< (F - 1);

  logic signed [PW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [WW-1:0] w_q, w_d;
  logic [JW-1:0]        j_q, j_d;

  logic                 dig_en;
  logic signed [1:0]    dx, dy, dz;
  logic signed [WW-1:0] ulp, v;
  logic signed [3:0]    s_dig;
  int                   sh;

  function automatic logic signed [1:0] dec(input logic [1:0] d);
    case (d)
      2'b10:   return 2'sb01;
      2'b01:   return 2'sb11;
      default: return 2'sb00;
    endcase
  endfunction

  // 2*A*a + a^2*ulp, with a restricted to {-1, 0, +1}
  function automatic logic signed [WW-1:0] inc_of(input logic signed [PW-1:0] a_pre,
                                                  input logic signed [1:0]    dig,
                                                  input logic signed [WW-1:0] u);
    logic signed [WW-1:0] a2;
    a2 = WW'(a_pre) <<< 1;
    case (dig)
      2'sb01:  return a2 + u;
      2'sb11:  return u - a2;
      default: return '0;
    endcase
  endfunction

  function automatic logic signed [PW-1:0] upd(input logic signed [PW-1:0] a_pre,
                                               input logic signed [1:0]    dig,
                                               input logic signed [WW-1:0] u);
    case (dig)
      2'sb01:  return a_pre + PW'(u);
      2'sb11:  return a_pre - PW'(u);
      default: return a_pre;
    endcase
  endfunction

  always_comb begin
    dig_en = en && !rst && (j_q != '0) && (int'(j_q) < WIDTH);
    dx     = dig_en ? dec(x) : 2'sb00;
    dy     = dig_en ? dec(y) : 2'sb00;
    dz     = dig_en ? dec(z) : 2'sb00;

    sh  = F - int'(j_q);
    ulp = '0;
    if (j_q != '0 && sh >= 0) ulp = WW'(1) <<< sh;

    v     = (w_q <<< 1) + inc_of(x_q, dx, ulp) + inc_of(y_q, dy, ulp) + inc_of(z_q, dz, ulp);
    // floor(v + 1/2): ties round toward +inf
    s_dig = 4'((v + HALF) >>> F);
    w_d   = v - (WW'(s_dig) <<< F);

    x_d = upd(x_q, dx, ulp);
    y_d = upd(y_q, dy, ulp);
    z_d = upd(z_q, dz, ulp);
    j_d = (j_q == JW'(WIDTH)) ? j_q : j_q + JW'(1);
  end

  assign s = (en && !rst && j_q != '0) ? s_dig : 4'd0;

  // en=0 clears the operation exactly like reset
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      w_q <= '0;
      j_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      w_q <= w_d;
      j_q <= j_d;
    end
  end

endmodule

// File: tb/tb_so3s_online.sv
// Self-checking bench for so3s_online: directed scenarios plus randomized operations
// compared against a real-valued reference model of the online recurrence.
module tb_so3s_online;

  localparam int WIDTH = 15;
  localparam int TW    = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] x, y, z;
  logic [3:0] s;

  int n_checks = 0;
  int n_errors = 0;

  real mX, mY, mZ, mW;
  int  mj;

  so3s_online #(.WIDTH(WIDTH), .TRUNCATED_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .x   (x),
    .y   (y),
    .z   (z),
    .s   (s)
  );

  always #5 clk = ~clk;

  function automatic int dval(input logic [1:0] d);
    if (d == 2'b10) return 1;
    if (d == 2'b01) return -1;
    return 0;
  endfunction

  function automatic void model_clear();
    mX = 0.0; mY = 0.0; mZ = 0.0; mW = 0.0; mj = 0;
  endfunction

  // Reference: v = 2w + sum(2*A*a + a^2*2^-j), s = floor(v + 1/2), w = v - s
  function automatic int model_step(input logic r, input logic e,
                                    input logic [1:0] dx, input logic [1:0] dy, input logic [1:0] dz);
    real ax, ay, az, ulp, v;
    int  se;
    if (r || !e) begin
      model_clear();
      return 0;
    end
    if (mj == 0) begin
      mj = 1;
      return 0;
    end
    ax  = (mj < WIDTH) ? real'(dval(dx)) : 0.0;
    ay  = (mj < WIDTH) ? real'(dval(dy)) : 0.0;
    az  = (mj < WIDTH) ? real'(dval(dz)) : 0.0;
    ulp = (mj <= TW) ? 1.0 / (2.0 ** mj) : 0.0;
    v   = 2.0 * mW + 2.0 * mX * ax + ax * ax * ulp
                   + 2.0 * mY * ay + ay * ay * ulp
                   + 2.0 * mZ * az + az * az * ulp;
    se  = $rtoi($floor(v + 0.5));
    mW  = v - real'(se);
    mX  = mX + ax * ulp;
    mY  = mY + ay * ulp;
    mZ  = mZ + az * ulp;
    if (mj < WIDTH) mj = mj + 1;
    return se;
  endfunction

  task automatic step(input logic r, input logic e,
                      input logic [1:0] dx, input logic [1:0] dy, input logic [1:0] dz,
                      output int obs, output int expv);
    @(negedge clk);
    rst = r; en = e; x = dx; y = dy; z = dz;
    #1;
    obs  = int'($signed(s));
    expv = model_step(r, e, dx, dy, dz);
    @(posedge clk);
  endtask

  task automatic test_reset();
    int obs, ev;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 2'($urandom), 2'($urandom), 2'($urandom), obs, ev);
      n_checks++;
      if (obs !== 0) begin
        n_errors++;
        $display("FAIL reset_s cyc=%0d got=%0d exp=0", i, obs);
      end
    end
  endtask

  task automatic test_zero();
    int  obs, ev;
    real sum = 0.0;
    step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, obs, ev);
    for (int j = 0; j < WIDTH; j++) begin
      step(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, obs, ev);
      sum += real'(obs) / (2.0 ** j);
      n_checks++;
      if (obs !== 0) begin
        n_errors++;
        $display("FAIL zero_s j=%0d got=%0d exp=0", j, obs);
      end
    end
    n_checks++;
    if (sum != 0.0) begin
      n_errors++;
      $display("FAIL zero_sum got=%f exp=0", sum);
    end
  endtask

  task automatic test_three_quarters();
    int  obs, ev, e;
    real sum = 0.0;
    logic [1:0] d;
    step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, obs, ev);
    for (int j = 0; j < WIDTH; j++) begin
      d = (j == 1 || j == 2) ? 2'b10 : 2'b00;
      e = (j == 1) ? 2 : (j == 2) ? 3 : (j == 4) ? -1 : 0;
      step(1'b0, 1'b1, d, d, d, obs, ev);
      sum += real'(obs) / (2.0 ** j);
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL sq075_s j=%0d got=%0d exp=%0d", j, obs, e);
      end
    end
    n_checks++;
    if (sum != 1.6875) begin
      n_errors++;
      $display("FAIL sq075_sum got=%f exp=1.6875", sum);
    end
  endtask

  task automatic test_negative();
    int  obs, ev, e;
    real sum = 0.0;
    step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, obs, ev);
    for (int j = 0; j < WIDTH; j++) begin
      e = (j == 1) ? 1 : (j == 2) ? -1 : 0;
      step(1'b0, 1'b1, (j == 1) ? 2'b01 : 2'b00, 2'b00, 2'b00, obs, ev);
      sum += real'(obs) / (2.0 ** j);
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL neg_s j=%0d got=%0d exp=%0d", j, obs, e);
      end
    end
    n_checks++;
    if (sum != 0.25) begin
      n_errors++;
      $display("FAIL neg_sum got=%f exp=0.25", sum);
    end
  endtask

  task automatic test_all_ones();
    int  obs, ev;
    real sum = 0.0, target, tol;
    step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, obs, ev);
    for (int j = 0; j < WIDTH; j++) begin
      step(1'b0, 1'b1, 2'b10, 2'b10, 2'b10, obs, ev);
      sum += real'(obs) / (2.0 ** j);
      n_checks++;
      if (obs !== ev || obs < -7 || obs > 7) begin
        n_errors++;
        $display("FAIL ones_s j=%0d got=%0d exp=%0d", j, obs, ev);
      end
    end
    target = 3.0 * (1.0 - 1.0 / (2.0 ** 14)) * (1.0 - 1.0 / (2.0 ** 14));
    tol    = 1.0 / (2.0 ** 15);
    n_checks++;
    if (sum - target > tol || target - sum > tol) begin
      n_errors++;
      $display("FAIL ones_sum got=%f exp=%f", sum, target);
    end
  endtask

  task automatic test_reset_mid();
    int obs, ev, e;
    logic [1:0] d;
    step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, obs, ev);
    for (int j = 0; j < 3; j++) begin
      d = (j == 1 || j == 2) ? 2'b10 : 2'b00;
      step(1'b0, 1'b1, d, d, d, obs, ev);
    end
    step(1'b1, 1'b1, 2'b10, 2'b10, 2'b10, obs, ev);
    n_checks++;
    if (obs !== 0) begin
      n_errors++;
      $display("FAIL rstmid_s got=%0d exp=0", obs);
    end
    for (int j = 0; j < WIDTH; j++) begin
      d = (j == 1 || j == 2) ? 2'b10 : 2'b00;
      e = (j == 1) ? 2 : (j == 2) ? 3 : (j == 4) ? -1 : 0;
      step(1'b0, 1'b1, d, d, d, obs, ev);
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL rstmid_restart j=%0d got=%0d exp=%0d", j, obs, e);
      end
    end
  endtask

  task automatic test_en_drop();
    int obs, ev, e;
    logic [1:0] dx;
    step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, obs, ev);
    for (int j = 0; j < 6; j++) begin
      step(1'b0, 1'b1, 2'($urandom), 2'($urandom), 2'($urandom), obs, ev);
      n_checks++;
      if (obs !== ev) begin
        n_errors++;
        $display("FAIL endrop_op1 j=%0d got=%0d exp=%0d", j, obs, ev);
      end
    end
    step(1'b0, 1'b0, 2'b10, 2'b10, 2'b10, obs, ev);
    n_checks++;
    if (obs !== 0) begin
      n_errors++;
      $display("FAIL endrop_idle got=%0d exp=0", obs);
    end
    // digit-0 input ignored, 2'b11 acts as 0, post-WIDTH inputs ignored
    for (int j = 0; j < WIDTH + 3; j++) begin
      dx = (j == 0) ? 2'b10 : (j == 1) ? 2'b01 : (j >= WIDTH) ? 2'b10 : 2'b11;
      e  = (j == 1) ? 1 : (j == 2) ? -1 : 0;
      step(1'b0, 1'b1, dx, (j >= WIDTH) ? 2'b10 : 2'b11, 2'b11, obs, ev);
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL endrop_op2 j=%0d got=%0d exp=%0d", j, obs, e);
      end
    end
  endtask

  task automatic test_random();
    int  obs, ev, len;
    real sum, sq, tol;
    tol = 1.0 / (2.0 ** 15);
    for (int op = 0; op < 25; op++) begin
      step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, obs, ev);
      sum = 0.0;
      len = WIDTH + int'($urandom_range(0, 4));
      for (int j = 0; j < len; j++) begin
        step(1'b0, 1'b1, 2'($urandom), 2'($urandom), 2'($urandom), obs, ev);
        if (j < WIDTH) sum += real'(obs) / (2.0 ** j);
        n_checks++;
        if (obs !== ev || obs < -7 || obs > 7) begin
          n_errors++;
          $display("FAIL rand_s op=%0d j=%0d got=%0d exp=%0d", op, j, obs, ev);
        end
      end
      sq = mX * mX + mY * mY + mZ * mZ;
      n_checks++;
      if (sum - sq > tol || sq - sum > tol) begin
        n_errors++;
        $display("FAIL rand_acc op=%0d got=%f exp=%f", op, sum, sq);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; x = 2'b00; y = 2'b00; z = 2'b00;
    model_clear();
    test_reset();
    test_zero();
    test_three_quarters();
    test_negative();
    test_all_ones();
    test_reset_mid();
    test_en_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/so3s_online.md
Name: so3s_online

Overview:
- Radix-2 online (MSDF) sum-of-three-squares unit: S = X² + Y² + Z².
- X, Y and Z arrive one signed digit per cycle, most significant first.
- One output digit of S is produced in the same cycle each input digit is presented (online delay 0).
- Serial arithmetic building block in the online datapath; digits use the rbr_pkg signed_digit encoding.

Parameters:
- WIDTH, 15: digits per operand, including index 0; sizes the digit index counter.
- TRUNCATED_WIDTH, 15: fractional bits kept in the operand prefix registers and the residual. Increment bits below 2^-TRUNCATED_WIDTH are dropped.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  digit valid / operation active.
- x  input  2  signed_digit {plus, minus}; value = plus − minus; 2'b11 decodes as 0.
- y  input  2  same encoding as x.
- z  input  2  same encoding as x.
- s  output  4  output digit, two's complement, range [-7, 7].

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. rst has priority over en.
- State: operand prefixes X, Y, Z (signed, TRUNCATED_WIDTH fractional bits); residual w (signed, 4 integer bits + TRUNCATED_WIDTH fractional bits); digit index j (saturating at WIDTH).
- Reset: at the clk edge with rst=1, X=Y=Z=0, w=0, j=0. s=0 whenever rst=1 or en=0.
- Operand values: X = Σ x_j·2^-j, and likewise Y and Z. The digit at j=0 is the integer digit and is treated as 0 regardless of input, so |X|, |Y|, |Z| < 1.
- Combinational path, cycle with en=1 and digit index j ≥ 1, per operand with prefix A (digits 1..j-1) and new digit a:
  - inc_A = 2·A·a + a²·2^-j.
  - v = 2w + inc_X + inc_Y + inc_Z.
  - s = floor(v + 1/2), i.e. round to nearest with ties rounding up.
- At j=0: s=0.
- Clock edge with en=1:
  - w ← v − s; invariant w ∈ [-1/2, 1/2).
  - X ← X + x·2^-j, likewise Y and Z.
  - j ← min(j+1, WIDTH).
- Digit range: |inc| < 2 per operand, so v ∈ (-7, 7) and s ∈ [-7, 7]. No overflow is possible on a 4-bit s.
- Clock edge with en=0 (and rst=0): state clears exactly as on reset. The next en=1 cycle is digit 0 of a new operation.
- After WIDTH digits (j = WIDTH): inputs are ignored and treated as 0. s continues to drain the residual (s = round(2w)); w keeps updating.
- Accuracy: after digit j, |(X²+Y²+Z²)_prefix − Σ s_i·2^-i| ≤ 2^-(j+1), exact up to truncation when TRUNCATED_WIDTH ≥ WIDTH.
- Reset mid-operation: state is cleared at that edge; in-flight digits are discarded.
- Timing: s must be stable before the next rising edge after the inputs change.

Test Plan:
- Reset then all-zero digits for 15 cycles with en=1 -> s=0 every cycle, Σ s·2^-j = 0.
- x=y=z=+1 at j=1,2 and 0 elsewhere (X=Y=Z=0.75) -> s sequence 0, 2, 3, 0, -1, 0, …; Σ s·2^-j = 1.6875 = 3·0.5625.
- x=-1 at j=1, all other digits 0 -> s = 0, 1, -1, 0, …; sum 0.25.
- x=y=z=+1 for j=1..14 -> every s within [-7, 7]; final sum = 3·(1−2^-14)² within 2^-15.
- rst=1 at j=3 mid-operation, then restart with the second scenario's stimulus -> identical digits to the second scenario, no carry-over.
- en dropped for one cycle between two operations; digit 2'b11 injected -> second operation is independent of the first; 2'b11 behaves as digit 0.
